// File: rtl/axi_stream_extract_header.sv
// AXI-Stream header extractor: strips a 1..DATA_BYTE_WD byte header from each packet and
// re-packs the payload MSB-first. Define AXIS_EXTRACT_HDR_ERR_EN to add the hdr_err output.
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
`ifdef AXIS_EXTRACT_HDR_ERR_EN
    ,
    output logic                    hdr_err
`endif
);

    localparam int CW = BYTE_CNT_WD + 2;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        BODY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic [CW-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [CW-1:0] n);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < int'(n));
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t state, state_nxt;

    logic [DATA_WD-1:0]      res_data;
    logic [CW-1:0]           res_cnt;

    logic                    hdr_free, out_free;
    logic [DATA_BYTE_WD-1:0] keep_eff;
    logic [CW-1:0]           n_in, hdr_len, hdr_rsh;
    logic [DATA_WD-1:0]      data_m;

    logic [DATA_WD-1:0]      hdr_data_nxt;
    logic [DATA_BYTE_WD-1:0] hdr_keep_nxt;
    logic [DATA_WD-1:0]      hdr_res_data;
    logic [CW-1:0]           hdr_res_cnt;

    logic [2*DATA_WD-1:0]    pack;
    logic [CW-1:0]           sum;
    logic [DATA_WD-1:0]      body_out, body_res_data;
    logic [DATA_BYTE_WD-1:0] body_keep;
    logic [CW-1:0]           body_res_cnt;

    logic                    load_hdr, load_out, res_we;
    logic [DATA_WD-1:0]      pay_data_nxt, res_data_nxt;
    logic [DATA_BYTE_WD-1:0] pay_keep_nxt;
    logic                    pay_last_nxt;
    logic [CW-1:0]           res_cnt_nxt;

    assign hdr_free = !valid_header || ready_header;
    assign out_free = !valid_out || ready_out;

    // Non-last beats are full regardless of keep_in; dropped lanes are zeroed so they never leak.
    assign keep_eff = last_in ? keep_in : '1;
    assign n_in     = popcount(keep_eff);
    assign data_m   = data_in & byte_mask(keep_eff);

    assign hdr_len      = CW'(byte_extract_cnt) + CW'(1);
    assign hdr_rsh      = CW'(DATA_BYTE_WD) - hdr_len;
    assign hdr_data_nxt = data_m >> {hdr_rsh, 3'b000};
    assign hdr_keep_nxt = keep_eff >> hdr_rsh;
    assign hdr_res_data = data_m << {hdr_len, 3'b000};
    assign hdr_res_cnt  = (n_in > hdr_len) ? (n_in - hdr_len) : '0;

    // Residue occupies the top of a double-width window; the new beat lands right behind it.
    assign pack = {res_data, {DATA_WD{1'b0}}} | ({data_m, {DATA_WD{1'b0}}} >> {res_cnt, 3'b000});
    assign sum  = res_cnt + n_in;

    always_comb begin
        body_out      = pack[2*DATA_WD-1 -: DATA_WD];
        body_res_data = pack[DATA_WD-1:0];
        if (sum >= CW'(DATA_BYTE_WD)) begin
            body_keep    = '1;
            body_res_cnt = sum - CW'(DATA_BYTE_WD);
        end else begin
            body_keep    = msb_mask(sum);
            body_res_cnt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR:     if (valid_in && ready_in && !last_in) state_nxt = BODY;
            BODY:    if (valid_in && ready_in && last_in)
                         state_nxt = (body_res_cnt == '0) ? HDR : FLUSH;
            FLUSH:   if (out_free) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    always_comb begin
        ready_in     = 1'b0;
        load_hdr     = 1'b0;
        load_out     = 1'b0;
        res_we       = 1'b0;
        pay_data_nxt = '0;
        pay_keep_nxt = '0;
        pay_last_nxt = 1'b0;
        res_data_nxt = '0;
        res_cnt_nxt  = '0;
        case (state)
            HDR: begin
                ready_in = hdr_free && out_free;
                if (valid_in && hdr_free && out_free) begin
                    load_hdr = 1'b1;
                    res_we   = 1'b1;
                    if (last_in) begin
                        // Header-only packet tail: the bytes after the header form the sole payload beat.
                        if (hdr_res_cnt != '0) begin
                            load_out     = 1'b1;
                            pay_data_nxt = hdr_res_data;
                            pay_keep_nxt = msb_mask(hdr_res_cnt);
                            pay_last_nxt = 1'b1;
                        end
                    end else begin
                        res_data_nxt = hdr_res_data;
                        res_cnt_nxt  = hdr_res_cnt;
                    end
                end
            end
            BODY: begin
                ready_in = out_free;
                if (valid_in && out_free) begin
                    load_out     = 1'b1;
                    res_we       = 1'b1;
                    pay_data_nxt = body_out;
                    pay_keep_nxt = body_keep;
                    pay_last_nxt = last_in && (body_res_cnt == '0);
                    if (!(last_in && body_res_cnt == '0)) begin
                        res_data_nxt = body_res_data;
                        res_cnt_nxt  = body_res_cnt;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_out     = 1'b1;
                    res_we       = 1'b1;
                    pay_data_nxt = res_data;
                    pay_keep_nxt = msb_mask(res_cnt);
                    pay_last_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
            res_cnt  <= '0;
        end else if (res_we) begin
            res_data <= res_data_nxt;
            res_cnt  <= res_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else if (load_hdr) begin
            valid_header <= 1'b1;
            data_header  <= hdr_data_nxt;
            keep_header  <= hdr_keep_nxt;
        end else if (ready_header) begin
            valid_header <= 1'b0;
        end
    end

`ifdef AXIS_EXTRACT_HDR_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        hdr_err <= 1'b0;
        else if (load_hdr) hdr_err <= (n_in < hdr_len);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (load_out) begin
            valid_out <= 1'b1;
            data_out  <= pay_data_nxt;
            keep_out  <= pay_keep_nxt;
            last_out  <= pay_last_nxt;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header (DATA_WD=32): header split, re-packing,
// flush, stalls, short header and mid-packet reset.
module tb_axi_stream_extract_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic [1:0]  byte_extract_cnt;
    logic        valid_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        ready_header;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
`ifdef AXIS_EXTRACT_HDR_ERR_EN
    logic        hdr_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] hq_data[$];
    logic [3:0]  hq_keep[$];
    logic        hq_err[$];
    logic [31:0] pq_data[$];
    logic [3:0]  pq_keep[$];
    logic        pq_last[$];

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .data_in          (data_in),
        .keep_in          (keep_in),
        .last_in          (last_in),
        .ready_in         (ready_in),
        .byte_extract_cnt (byte_extract_cnt),
        .valid_header     (valid_header),
        .data_header      (data_header),
        .keep_header      (keep_header),
        .ready_header     (ready_header),
        .valid_out        (valid_out),
        .data_out         (data_out),
        .keep_out         (keep_out),
        .last_out         (last_out),
        .ready_out        (ready_out)
`ifdef AXIS_EXTRACT_HDR_ERR_EN
        ,
        .hdr_err          (hdr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfers are captured mid-cycle; inputs only change just after the rising edge.
    always @(negedge clk) begin
        if (rst_n && valid_header && ready_header) begin
            hq_data.push_back(data_header);
            hq_keep.push_back(keep_header);
`ifdef AXIS_EXTRACT_HDR_ERR_EN
            hq_err.push_back(hdr_err);
`else
            hq_err.push_back(1'b0);
`endif
        end
        if (rst_n && valid_out && ready_out) begin
            pq_data.push_back(data_out);
            pq_keep.push_back(keep_out);
            pq_last.push_back(last_out);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        hq_data.delete(); hq_keep.delete(); hq_err.delete();
        pq_data.delete(); pq_keep.delete(); pq_last.delete();
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] c);
        int n;
        n = 0;
        data_in = d; keep_in = k; last_in = l; byte_extract_cnt = c; valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ready_in) begin
            errors++;
            $display("FAIL send_timeout: ready_in=%b required 1 (data %h)", ready_in, d);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (valid_header !== 1'b0 || valid_out !== 1'b0 || last_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: vh=%b vo=%b lo=%b required 0 0 0", valid_header, valid_out, last_out);
        end
        checks++;
        if (data_out !== 32'h0 || keep_out !== 4'h0 || data_header !== 32'h0 || keep_header !== 4'h0) begin
            errors++;
            $display("FAIL reset_data: do=%h ko=%h dh=%h kh=%h required zeros", data_out, keep_out, data_header, keep_header);
        end
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_in=%b required 1", ready_in);
        end
`ifdef AXIS_EXTRACT_HDR_ERR_EN
        checks++;
        if (hdr_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_hdr_err: got %b required 0", hdr_err);
        end
`endif
    endtask

    task automatic test_h3_basic(input string tag);
        logic [31:0] ed[2];
        logic [3:0]  ek[2];
        logic        el[2];
        ed = '{32'hDD112233, 32'h44556600};
        ek = '{4'b1111, 4'b1110};
        el = '{1'b0, 1'b1};
        clear_q();
        send(32'hAABBCCDD, 4'b1111, 1'b0, 2'd2);
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_early_payload: valid_out=%b required 0", tag, valid_out);
        end
        send(32'h11223344, 4'b1111, 1'b0, 2'd2);
        send(32'h55667788, 4'b1100, 1'b1, 2'd2);
        idle(4);
        checks++;
        if (hq_data.size() != 1) begin
            errors++;
            $display("FAIL %s_hdr_count: got %0d required 1", tag, hq_data.size());
        end else begin
            checks++;
            if (hq_data[0] !== 32'h00AABBCC || hq_keep[0] !== 4'b0111 || hq_err[0] !== 1'b0) begin
                errors++;
                $display("FAIL %s_hdr: got %h/%b err %b required 00aabbcc/0111 err 0", tag, hq_data[0], hq_keep[0], hq_err[0]);
            end
        end
        checks++;
        if (pq_data.size() != 2) begin
            errors++;
            $display("FAIL %s_pay_count: got %0d required 2", tag, pq_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pq_data[i] !== ed[i] || pq_keep[i] !== ek[i] || pq_last[i] !== el[i]) begin
                    errors++;
                    $display("FAIL %s_pay%0d: got %h/%b/%b required %h/%b/%b", tag, i,
                             pq_data[i], pq_keep[i], pq_last[i], ed[i], ek[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_passthrough();
        clear_q();
        send(32'hA0A0A0A0, 4'b1111, 1'b0, 2'd3);
        checks++;
        if (valid_header !== 1'b1 || data_header !== 32'hA0A0A0A0 || keep_header !== 4'b1111) begin
            errors++;
            $display("FAIL pt_hdr_latency: vh=%b %h/%b required 1 a0a0a0a0/1111", valid_header, data_header, keep_header);
        end
        send(32'hB0B0B0B0, 4'b1111, 1'b1, 2'd3);
        checks++;
        if (valid_out !== 1'b1 || data_out !== 32'hB0B0B0B0 || keep_out !== 4'b1111 || last_out !== 1'b1) begin
            errors++;
            $display("FAIL pt_pay_latency: vo=%b %h/%b/%b required 1 b0b0b0b0/1111/1", valid_out, data_out, keep_out, last_out);
        end
        idle(3);
        checks++;
        if (hq_data.size() != 1 || pq_data.size() != 1) begin
            errors++;
            $display("FAIL pt_counts: hdr %0d pay %0d required 1 1", hq_data.size(), pq_data.size());
        end
    endtask

    task automatic test_flush();
        clear_q();
        send(32'h01020304, 4'b1111, 1'b0, 2'd0);
        send(32'h05060708, 4'b1111, 1'b1, 2'd0);
        checks++;
        if (ready_in !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_in: got %b required 0", ready_in);
        end
        idle(4);
        checks++;
        if (hq_data.size() != 1 || hq_data[0] !== 32'h00000001 || hq_keep[0] !== 4'b0001) begin
            errors++;
            $display("FAIL flush_hdr: count %0d first %h/%b required 1 00000001/0001", hq_data.size(),
                     (hq_data.size() > 0) ? hq_data[0] : 32'hX, (hq_keep.size() > 0) ? hq_keep[0] : 4'hX);
        end
        checks++;
        if (pq_data.size() != 2) begin
            errors++;
            $display("FAIL flush_pay_count: got %0d required 2", pq_data.size());
        end else begin
            checks++;
            if (pq_data[0] !== 32'h02030405 || pq_keep[0] !== 4'b1111 || pq_last[0] !== 1'b0) begin
                errors++;
                $display("FAIL flush_pay0: got %h/%b/%b required 02030405/1111/0", pq_data[0], pq_keep[0], pq_last[0]);
            end
            checks++;
            if (pq_data[1] !== 32'h06070800 || pq_keep[1] !== 4'b1110 || pq_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL flush_pay1: got %h/%b/%b required 06070800/1110/1", pq_data[1], pq_keep[1], pq_last[1]);
            end
        end
    endtask

    task automatic test_stall();
        clear_q();
        ready_out = 1'b0;
        send(32'hAABBCCDD, 4'b1111, 1'b0, 2'd2);
        send(32'h11223344, 4'b1111, 1'b0, 2'd2);
        data_in = 32'h55667788; keep_in = 4'b1100; last_in = 1'b1; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== 32'hDD112233 || keep_out !== 4'b1111) begin
                errors++;
                $display("FAIL stall_out_hold%0d: ri=%b vo=%b %h/%b required 0 1 dd112233/1111", i,
                         ready_in, valid_out, data_out, keep_out);
            end
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        send(32'h55667788, 4'b1100, 1'b1, 2'd2);
        idle(3);
        checks++;
        if (pq_data.size() != 2 || pq_data[0] !== 32'hDD112233 || pq_data[1] !== 32'h44556600 || pq_last[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_out_stream: count %0d required 2 beats dd112233, 44556600 last", pq_data.size());
        end

        clear_q();
        ready_header = 1'b0;
        send(32'h12345678, 4'b1111, 1'b1, 2'd3);
        data_in = 32'hCAFEF00D; keep_in = 4'b1111; last_in = 1'b1; byte_extract_cnt = 2'd1; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_in !== 1'b0 || valid_header !== 1'b1 || data_header !== 32'h12345678) begin
                errors++;
                $display("FAIL stall_hdr_hold%0d: ri=%b vh=%b dh=%h required 0 1 12345678", i,
                         ready_in, valid_header, data_header);
            end
        end
        @(posedge clk);
        #1;
        ready_header = 1'b1;
        send(32'hCAFEF00D, 4'b1111, 1'b1, 2'd1);
        idle(3);
        checks++;
        if (hq_data.size() != 2 || hq_data[0] !== 32'h12345678 || hq_keep[0] !== 4'b1111 ||
            hq_data[1] !== 32'h0000CAFE || hq_keep[1] !== 4'b0011) begin
            errors++;
            $display("FAIL stall_hdr_stream: count %0d required 12345678/1111 then 0000cafe/0011", hq_data.size());
        end
        checks++;
        if (pq_data.size() != 1 || pq_data[0] !== 32'hF00D0000 || pq_keep[0] !== 4'b1100 || pq_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hdr_pay: count %0d required f00d0000/1100/1", pq_data.size());
        end
    endtask

    task automatic test_short_hdr();
        clear_q();
        send(32'hAABB0000, 4'b1100, 1'b1, 2'd2);
        idle(3);
        checks++;
        if (hq_data.size() != 1 || hq_data[0] !== 32'h00AABB00 || hq_keep[0] !== 4'b0110) begin
            errors++;
            $display("FAIL short_hdr: count %0d first %h/%b required 00aabb00/0110", hq_data.size(),
                     (hq_data.size() > 0) ? hq_data[0] : 32'hX, (hq_keep.size() > 0) ? hq_keep[0] : 4'hX);
        end
        checks++;
        if (pq_data.size() != 0) begin
            errors++;
            $display("FAIL short_no_payload: got %0d beats required 0", pq_data.size());
        end
`ifdef AXIS_EXTRACT_HDR_ERR_EN
        checks++;
        if (hq_err.size() != 1 || hq_err[0] !== 1'b1) begin
            errors++;
            $display("FAIL short_hdr_err: count %0d required one entry with hdr_err=1", hq_err.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        send(32'h01020304, 4'b1111, 1'b0, 2'd0);
        send(32'h05060708, 4'b1111, 1'b0, 2'd0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || valid_header !== 1'b0 || last_out !== 1'b0 || data_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: vo=%b vh=%b lo=%b do=%h required 0 0 0 0", valid_out, valid_header, last_out, data_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        test_h3_basic("rst_mid");
    endtask

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0; byte_extract_cnt = '0;
        ready_header = 1'b1; ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        idle(1);
        test_reset();
        test_h3_basic("h3");
        test_passthrough();
        test_flush();
        test_stall();
        test_short_hdr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
